trdb_encoder_ctrl: RTL and testbench
====================================

# trdb_encoder_ctrl

Trace-encoder sequencing controller that sits in front of `trdb_priority` and the packet emitter. It owns the encoder on/off state machine and the resync timer. It generates the enable/disable/opmode-change support-packet requests and the qualification-edge flags (`first_qualified`, `final_qualified`, `max_resync`) that the packet-priority logic consumes. It also holds each support request until the emitter acknowledges it.

## Interface
- `RESYNC_W`, default 16: width of the resync counter and threshold.
- `OPMODE_W`, default 2: width of the trace operating-mode field.

- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `enable_req_i` in 1: trace enable request, level.
- `disable_req_i` in 1: trace disable request, level.
- `opmode_i` in OPMODE_W: requested operating mode.
- `resync_max_i` in RESYNC_W: resync threshold; 0 disables the timer.
- `valid_i` in 1: instruction retired this cycle.
- `qualified_i` in 1: filter result for the retired instruction.
- `halted_i` in 1: core-halted sideband.
- `core_reset_i` in 1: core-in-reset sideband.
- `resync_rst_i` in 1: counter clear, driven by `resync_rst_o` of the priority block.
- `support_ack_i` in 1: emitter accepted the pending support packet.
- `trace_on_o` out 1: encoder is in TRACING; gates `valid_i` into the priority block.
- `tc_enc_enabled_o` out 1: support-packet request, start of trace.
- `tc_enc_disabled_o` out 1: support-packet request, end of trace.
- `tc_opmode_change_o` out 1: support-packet request, mode change.
- `opmode_o` out OPMODE_W: currently active mode.
- `tc_first_qualified_o` out 1: first qualified retirement since trace-on or since the last unqualified retirement.
- `lc_final_qualified_o` out 1: the previous valid retirement was the last qualified one.
- `tc_max_resync_o` out 1: resync timer expired.

## Operation
- Effective qualification: `q_eff = qualified_i & ~halted_i & ~core_reset_i`. A halted or reset core is treated as unqualified.
- States and outputs:
  - OFF: all outputs 0.
  - START_PEND: `tc_enc_enabled_o=1`.
  - TRACING: `trace_on_o=1`.
  - MODE_PEND: `tc_opmode_change_o=1`.
  - STOP_PEND: `tc_enc_disabled_o=1`.
- Transitions:
  - OFF → START_PEND on `enable_req_i`; `opmode_o` loads `opmode_i`.
  - START_PEND → TRACING on `support_ack_i`. If a disable was latched during START_PEND, go to STOP_PEND instead.
  - TRACING → STOP_PEND on `disable_req_i`. Otherwise → MODE_PEND if `opmode_i != opmode_o`. Disable wins when both occur together.
  - MODE_PEND → TRACING on `support_ack_i`; `opmode_o` loads `opmode_i` on the ack cycle. A `disable_req_i` during MODE_PEND is latched and taken on the ack (→ STOP_PEND).
  - STOP_PEND → OFF on `support_ack_i`. `enable_req_i` is ignored until OFF is reached.
- Support requests are levels held until ack. At most one support request is high in any cycle.
- Qualification tracking is active only in TRACING, on `valid_i` cycles:
  - Register `last_q` holds the q_eff of the last valid retirement. It is cleared on entry to TRACING and in every non-TRACING state.
  - `tc_first_qualified_o = valid_i & q_eff & ~last_q`, combinational.
  - `lc_final_qualified_o = valid_i & ~q_eff & last_q`, combinational.
  - Cycles with `valid_i=0` leave `last_q` unchanged.
- Resync counter `cnt` (RESYNC_W bits):
  - Increments on `valid_i & q_eff` in TRACING and saturates at all-ones.
  - Clears on `resync_rst_i`, on entry to TRACING, and in every other state. Clear has priority over increment in the same cycle.
  - `tc_max_resync_o = (resync_max_i != 0) & (cnt >= resync_max_i) & trace_on_o`.

## Timing
- Reset (async assert, clock-synchronous release): state OFF, `last_q=0`, `cnt=0`, `opmode_o=0`, latched disable 0, all outputs 0.
- `enable_req_i` high at edge N: `tc_enc_enabled_o` is high from cycle N+1.
- Ack sampled at edge M: the next state is visible from M+1, and the request drops in M+1.
- Flags `tc_first_qualified_o` and `lc_final_qualified_o` are zero-latency combinational on inputs plus registered `last_q`. `tc_max_resync_o` is combinational on the registered `cnt`.
- An ack while no request is pending is ignored.
- Mid-operation reset returns to OFF with no disable packet issued.

## Test plan
- Enable then ack 3 cycles later: `tc_enc_enabled_o` is high for exactly the 3 waiting cycles plus the ack cycle; `trace_on_o` rises the cycle after the ack.
- In TRACING, retirements with qualification 0,1,1,0: `tc_first_qualified_o` pulses on the 2nd retirement and `lc_final_qualified_o` pulses on the 4th.
- Qualified retirement with `halted_i=1` after a qualified one: it counts as unqualified, so `lc_final_qualified_o=1`.
- `resync_max_i=4`, 4 qualified retirements: `tc_max_resync_o` asserts after the 4th. Then `resync_rst_i` plus a simultaneous qualified retirement: `cnt=0` and the flag drops.
- `opmode_i` change 2→3 together with `disable_req_i` in TRACING: enters STOP_PEND, and `tc_opmode_change_o` is never asserted.
- `disable_req_i` during START_PEND, then ack: goes directly to STOP_PEND, `tc_enc_disabled_o=1`; a second ack returns to OFF. `rst_i` asserted in STOP_PEND: all outputs 0 immediately.

Source files
------------

// File: rtl/trdb_encoder_ctrl.sv
// Trace-encoder sequencing controller: on/off state machine, support-packet
// requests held until acknowledged, qualification-edge flags and resync timer.
module trdb_encoder_ctrl #(
  parameter int RESYNC_W = 16,
  parameter int OPMODE_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_req_i,
  input  logic                disable_req_i,
  input  logic [OPMODE_W-1:0] opmode_i,
  input  logic [RESYNC_W-1:0] resync_max_i,
  input  logic                valid_i,
  input  logic                qualified_i,
  input  logic                halted_i,
  input  logic                core_reset_i,
  input  logic                resync_rst_i,
  input  logic                support_ack_i,
  output logic                trace_on_o,
  output logic                tc_enc_enabled_o,
  output logic                tc_enc_disabled_o,
  output logic                tc_opmode_change_o,
  output logic [OPMODE_W-1:0] opmode_o,
  output logic                tc_first_qualified_o,
  output logic                lc_final_qualified_o,
  output logic                tc_max_resync_o
);

  typedef enum logic [2:0] {
    S_OFF,
    S_START_PEND,
    S_TRACING,
    S_MODE_PEND,
    S_STOP_PEND
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_dis_lat, w_dis_lat_nxt;
  logic [OPMODE_W-1:0] r_opmode, w_opmode_nxt;
  logic                r_last_q, w_last_q_nxt;
  logic [RESYNC_W-1:0] r_cnt, w_cnt_nxt;
  logic                w_q_eff;
  logic                w_tracing;

  function automatic logic [RESYNC_W-1:0] sat_inc(input logic [RESYNC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_q_eff   = qualified_i & ~halted_i & ~core_reset_i;
  assign w_tracing = (r_state == S_TRACING);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_OFF;
      r_dis_lat <= 1'b0;
      r_opmode  <= '0;
      r_last_q  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dis_lat <= w_dis_lat_nxt;
      r_opmode  <= w_opmode_nxt;
      r_last_q  <= w_last_q_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // A disable seen on the ack cycle itself counts the same as one latched earlier.
  always_comb begin
    w_state_nxt        = r_state;
    w_dis_lat_nxt      = 1'b0;
    w_opmode_nxt       = r_opmode;
    trace_on_o         = 1'b0;
    tc_enc_enabled_o   = 1'b0;
    tc_enc_disabled_o  = 1'b0;
    tc_opmode_change_o = 1'b0;
    case (r_state)
      S_OFF: begin
        if (enable_req_i) begin
          w_state_nxt  = S_START_PEND;
          w_opmode_nxt = opmode_i;
        end
      end
      S_START_PEND: begin
        tc_enc_enabled_o = 1'b1;
        if (support_ack_i) begin
          w_state_nxt = (r_dis_lat | disable_req_i) ? S_STOP_PEND : S_TRACING;
        end else begin
          w_dis_lat_nxt = r_dis_lat | disable_req_i;
        end
      end
      S_TRACING: begin
        trace_on_o = 1'b1;
        if (disable_req_i) begin
          w_state_nxt = S_STOP_PEND;
        end else if (opmode_i != r_opmode) begin
          w_state_nxt = S_MODE_PEND;
        end
      end
      S_MODE_PEND: begin
        tc_opmode_change_o = 1'b1;
        if (support_ack_i) begin
          w_opmode_nxt = opmode_i;
          w_state_nxt  = (r_dis_lat | disable_req_i) ? S_STOP_PEND : S_TRACING;
        end else begin
          w_dis_lat_nxt = r_dis_lat | disable_req_i;
        end
      end
      S_STOP_PEND: begin
        tc_enc_disabled_o = 1'b1;
        if (support_ack_i) begin
          w_state_nxt = S_OFF;
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  // Tracking state is held at zero outside TRACING, which also covers entry.
  always_comb begin
    w_last_q_nxt = 1'b0;
    w_cnt_nxt    = '0;
    if (w_tracing) begin
      w_last_q_nxt = valid_i ? w_q_eff : r_last_q;
      if (resync_rst_i) begin
        w_cnt_nxt = '0;
      end else if (valid_i & w_q_eff) begin
        w_cnt_nxt = sat_inc(r_cnt);
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end
  end

  assign opmode_o             = r_opmode;
  assign tc_first_qualified_o = w_tracing & valid_i & w_q_eff & ~r_last_q;
  assign lc_final_qualified_o = w_tracing & valid_i & ~w_q_eff & r_last_q;
  assign tc_max_resync_o      = w_tracing & (resync_max_i != '0) & (r_cnt >= resync_max_i);

endmodule

// File: tb/tb_trdb_encoder_ctrl.sv
// Bench for trdb_encoder_ctrl: directed scenarios followed by random traffic,
// all outputs compared each cycle against a behavioural model.
module tb_trdb_encoder_ctrl;
  localparam int RW      = 3;
  localparam int OW      = 2;
  localparam int CNT_MAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_req, disable_req, valid, qualified, halted, core_reset;
  logic          resync_rst, ack;
  logic [OW-1:0] opmode;
  logic [RW-1:0] resync_max;
  logic          trace_on_o, tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o;
  logic [OW-1:0] opmode_o;
  logic          tc_first_qualified_o, lc_final_qualified_o, tc_max_resync_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: tracing flag plus kind of pending packet (0 none, 1 enable, 2 mode, 3 disable)
  bit m_on;
  int m_pend;
  bit m_dis;
  int m_mode;
  bit m_lastq;
  int m_cnt;

  logic          s_on, s_en, s_dis, s_mc, s_first, s_final, s_max;
  logic [OW-1:0] s_mode;
  int            en_hi_cnt;
  bit            mc_seen;

  trdb_encoder_ctrl #(.RESYNC_W(RW), .OPMODE_W(OW)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .enable_req_i         (enable_req),
    .disable_req_i        (disable_req),
    .opmode_i             (opmode),
    .resync_max_i         (resync_max),
    .valid_i              (valid),
    .qualified_i          (qualified),
    .halted_i             (halted),
    .core_reset_i         (core_reset),
    .resync_rst_i         (resync_rst),
    .support_ack_i        (ack),
    .trace_on_o           (trace_on_o),
    .tc_enc_enabled_o     (tc_enc_enabled_o),
    .tc_enc_disabled_o    (tc_enc_disabled_o),
    .tc_opmode_change_o   (tc_opmode_change_o),
    .opmode_o             (opmode_o),
    .tc_first_qualified_o (tc_first_qualified_o),
    .lc_final_qualified_o (lc_final_qualified_o),
    .tc_max_resync_o      (tc_max_resync_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pend = 0; m_dis = 0; m_mode = 0; m_lastq = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    bit q;
    bit exp_max;
    q       = qualified & ~halted & ~core_reset;
    exp_max = m_on && (resync_max != 0) && (m_cnt >= int'(resync_max));
    chk("trace_on",       32'(trace_on_o),           32'(m_on));
    chk("enc_enabled",    32'(tc_enc_enabled_o),     32'(m_pend == 1));
    chk("opmode_change",  32'(tc_opmode_change_o),   32'(m_pend == 2));
    chk("enc_disabled",   32'(tc_enc_disabled_o),    32'(m_pend == 3));
    chk("opmode",         32'(opmode_o),             32'(m_mode));
    chk("first_qual",     32'(tc_first_qualified_o), 32'(m_on & valid & q & ~m_lastq));
    chk("final_qual",     32'(lc_final_qualified_o), 32'(m_on & valid & ~q & m_lastq));
    chk("max_resync",     32'(tc_max_resync_o),      32'(exp_max));
    s_on = trace_on_o; s_en = tc_enc_enabled_o; s_dis = tc_enc_disabled_o;
    s_mc = tc_opmode_change_o; s_mode = opmode_o; s_first = tc_first_qualified_o;
    s_final = lc_final_qualified_o; s_max = tc_max_resync_o;
    if (s_en) en_hi_cnt++;
    if (s_mc) mc_seen = 1;
  endtask

  task automatic model_step();
    bit q;
    q = qualified & ~halted & ~core_reset;
    if (rst) begin
      model_reset();
    end else if (m_on) begin
      if (resync_rst) m_cnt = 0;
      else if (valid && q && m_cnt < CNT_MAX) m_cnt++;
      if (valid) m_lastq = q;
      if (disable_req) begin
        m_on = 0; m_pend = 3;
      end else if (int'(opmode) != m_mode) begin
        m_on = 0; m_pend = 2;
      end
    end else begin
      case (m_pend)
        0: if (enable_req) begin m_pend = 1; m_mode = int'(opmode); end
        1, 2: begin
          if (ack) begin
            if (m_pend == 2) m_mode = int'(opmode);
            if (m_dis || disable_req) m_pend = 3;
            else begin m_pend = 0; m_on = 1; end
            m_dis = 0;
          end else begin
            m_dis = m_dis | disable_req;
          end
        end
        default: if (ack) m_pend = 0;
      endcase
    end
    if (!m_on) begin m_lastq = 0; m_cnt = 0; end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int pat[4];
    pat = '{0, 1, 1, 0};
    rst = 1; enable_req = 0; disable_req = 0; valid = 0; qualified = 0; halted = 0;
    core_reset = 0; resync_rst = 0; ack = 0; opmode = 0; resync_max = 4;
    en_hi_cnt = 0; mc_seen = 0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) cycle();
    rst = 0;
    cycle();

    // Enable, ack three cycles later
    opmode = 2; enable_req = 1; en_hi_cnt = 0;
    cycle();
    enable_req = 0;
    repeat (3) cycle();
    ack = 1; cycle(); ack = 0;
    cycle();
    chk("en_hi_cycles", 32'(en_hi_cnt), 32'd4);
    chk("trace_on_after_ack", 32'(s_on), 32'd1);

    // Qualification pattern 0,1,1,0
    valid = 1;
    for (int i = 0; i < 4; i++) begin
      qualified = pat[i][0];
      cycle();
      chk("pat_first", 32'(s_first), 32'(i == 1));
      chk("pat_final", 32'(s_final), 32'(i == 3));
    end

    // Halted core makes a qualified retirement unqualified
    qualified = 1; cycle();
    halted = 1; cycle();
    chk("halted_final", 32'(s_final), 32'd1);
    halted = 0; valid = 0;

    // Resync threshold, clear priority, saturation, zero threshold
    resync_rst = 1; cycle(); resync_rst = 0;
    resync_max = 4; valid = 1; qualified = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("max_before", 32'(s_max), 32'd0);
    end
    valid = 0; cycle();
    chk("max_after4", 32'(s_max), 32'd1);
    resync_rst = 1; valid = 1; cycle();
    resync_rst = 0; valid = 0; cycle();
    chk("max_cleared", 32'(s_max), 32'd0);
    resync_max = 7; valid = 1;
    repeat (9) cycle();
    valid = 0; cycle();
    chk("max_saturated", 32'(s_max), 32'd1);
    resync_max = 0; cycle();
    chk("max_zero_thr", 32'(s_max), 32'd0);
    resync_max = 4;

    // Mode change together with disable: disable wins
    mc_seen = 0; opmode = 3; disable_req = 1; cycle(); disable_req = 0;
    cycle();
    chk("dis_wins", 32'(s_dis), 32'd1);
    cycle();
    ack = 1; cycle(); ack = 0;
    cycle();
    chk("off_after_stop", 32'(s_on | s_dis), 32'd0);
    chk("no_mode_change", 32'(mc_seen), 32'd0);

    // Mode change, disable latched during MODE_PEND
    enable_req = 1; cycle(); enable_req = 0;
    ack = 1; cycle(); ack = 0;
    cycle();
    chk("opmode_loaded", 32'(s_mode), 32'd3);
    opmode = 1; cycle();
    cycle();
    chk("mode_pend", 32'(s_mc), 32'd1);
    disable_req = 1; cycle(); disable_req = 0;
    ack = 1; cycle(); ack = 0;
    cycle();
    chk("mode_to_stop", 32'(s_dis), 32'd1);
    chk("mode_ack_load", 32'(s_mode), 32'd1);
    ack = 1; cycle(); ack = 0;

    // Disable during START_PEND, then reset in STOP_PEND
    enable_req = 1; cycle(); enable_req = 0;
    disable_req = 1; cycle(); disable_req = 0;
    ack = 1; cycle(); ack = 0;
    cycle();
    chk("start_to_stop", 32'(s_dis), 32'd1);
    chk("start_no_trace", 32'(s_on), 32'd0);
    ack = 1; cycle(); ack = 0;
    cycle();
    chk("back_off", 32'(s_dis), 32'd0);
    enable_req = 1; cycle(); enable_req = 0;
    ack = 1; cycle(); ack = 0;
    disable_req = 1; cycle(); disable_req = 0;
    cycle();
    chk("stop_pend", 32'(s_dis), 32'd1);
    rst = 1; model_reset(); #1;
    check_outputs();
    chk("rst_immediate", 32'({s_on, s_en, s_dis, s_mc}), 32'd0);
    cycle();
    rst = 0;
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      enable_req  = ($urandom % 5) == 0;
      disable_req = ($urandom % 9) == 0;
      ack         = ($urandom % 3) == 0;
      if (($urandom % 16) == 0) opmode = OW'($urandom % 4);
      valid       = ($urandom % 2) == 0;
      qualified   = ($urandom % 3) != 0;
      halted      = ($urandom % 10) == 0;
      core_reset  = ($urandom % 12) == 0;
      resync_rst  = ($urandom % 15) == 0;
      if (($urandom % 32) == 0) resync_max = RW'($urandom % 8);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
